apb_master: RTL and testbench

- APB requester that turns a simple valid/ready command interface into APB transfers on the peripheral bus.
- Sits directly upstream of the team's APB slave and drives psel, penable, pwrite, paddr and pwdata into it.
- Returns read data and an error flag to the command source as a one-cycle response pulse.
- One outstanding transfer at a time. No pipelining beyond the APB ACCESS->SETUP back-to-back path.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_master.sv | 130 +++++++++++++
 tb/tb_apb_master.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus state encoding (common with the APB slave) and default widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 8;
    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    // Wait counter must hold 0..TIMEOUT; keep at least one bit when the timeout is disabled.
    function automatic int unsigned wait_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master.sv
// APB requester: accepts one valid/ready command at a time, runs it on APB and
// returns a one-cycle response pulse with read data and an error flag.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  prst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned        CNT_W    = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    apb_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic                  timeout_hit;
    logic                  done;
    logic                  accept;

    // Completion and handshake decode; the ACCESS->SETUP path lets a new command in on the completion edge.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_hit = (state_q == ACCESS) && !pready && (cnt_q == CNT_LAST);
        end
        done      = (state_q == ACCESS) && (pready || timeout_hit);
        cmd_ready = !prst && ((state_q == IDLE) || done);
        accept    = cmd_valid && cmd_ready;
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        pwrite_q <= cmd_write;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pready ? pslverr : 1'b1;
                        rsp_rdata_q <= (pready && !pwrite_q) ? prdata : '0;
                        penable_q   <= 1'b0;
                        if (accept) begin
                            paddr_q  <= cmd_addr;
                            pwdata_q <= cmd_wdata;
                            pwrite_q <= cmd_write;
                            state_q  <= SETUP;
                        end else begin
                            psel_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end else if (cnt_q != CNT_MAX) begin
                        // Saturate rather than wrap when the timeout is disabled.
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a transfer-level model (accept edge, completion edge,
// expected response per transfer) is compared against the DUT pins every cycle.
module tb_apb_master;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          pclk;
    logic          prst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    apb_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .pclk      (pclk),
        .prst      (prst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    // One planned transfer: accepted at edge a, completes at edge c.
    typedef struct {
        int            a;
        int            c;
        bit            wr;
        bit            to;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] srd;
        bit            serr;
        logic [DW-1:0] erdata;
        bit            eerr;
    } xfer_t;

    xfer_t         q[$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    bit            armed = 1'b0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, want);
        end
    endtask

    // A transfer occupies the requester until the cycle before its completion edge.
    function automatic bit model_busy(input int k);
        foreach (q[i]) if (q[i].a <= k && k + 1 < q[i].c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drop();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
    endtask

    // Present a command and hold it until the model says it is taken; returns the accept edge.
    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input bit to, input logic [DW-1:0] srd, input bit serr,
                         output int acc);
        xfer_t x;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        for (int n = 0; model_busy(cyc); n++) begin
            if (n > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_wait at cycle %0d: got no accept, want accept within 50 cycles", cyc);
                acc = -1;
                return;
            end
            step();
        end
        x.a      = cyc + 1;
        x.c      = to ? x.a + 1 + int'(TO) : x.a + 2 + waits;
        x.wr     = wr;
        x.to     = to;
        x.addr   = addr;
        x.wdata  = wdata;
        x.srd    = srd;
        x.serr   = serr;
        x.erdata = (to || wr) ? '0 : srd;
        x.eerr   = to ? 1'b1 : serr;
        q.push_back(x);
        acc = x.a;
        step();
    endtask

    // Slave side: pready only in the last ACCESS cycle of a planned transfer; junk otherwise.
    initial begin
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        forever begin
            step();
            pready  = 1'b0;
            prdata  = DW'($urandom);
            pslverr = 1'($urandom);
            foreach (q[i]) begin
                if (!q[i].to && q[i].c == cyc + 1) begin
                    pready  = 1'b1;
                    prdata  = q[i].srd;
                    pslverr = q[i].serr;
                end
            end
        end
    end

    // Per-cycle compare against the transfer-level model.
    initial begin
        forever begin
            @(negedge pclk);
            if (armed) begin : cmp
                bit    e_psel;
                bit    e_pen;
                bit    e_rv;
                bit    has_cur;
                xfer_t cur;
                e_psel  = 1'b0;
                e_pen   = 1'b0;
                e_rv    = 1'b0;
                has_cur = 1'b0;
                while (q.size() > 0 && q[0].c + 2 < cyc) void'(q.pop_front());
                foreach (q[i]) begin
                    if (q[i].a <= cyc && cyc < q[i].c) begin
                        e_psel  = 1'b1;
                        has_cur = 1'b1;
                        cur     = q[i];
                    end
                    if (q[i].a + 1 <= cyc && cyc < q[i].c) e_pen = 1'b1;
                    if (q[i].c == cyc) begin
                        e_rv       = 1'b1;
                        last_rdata = q[i].erdata;
                        last_err   = q[i].eerr;
                    end
                end
                chk("psel", 32'(psel), 32'(e_psel));
                chk("penable", 32'(penable), 32'(e_pen));
                chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
                chk("cmd_ready", 32'(cmd_ready), 32'(!prst && !model_busy(cyc)));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
                chk("rsp_err", 32'(rsp_err), 32'(last_err));
                if (has_cur) begin
                    chk("paddr", 32'(paddr), 32'(cur.addr));
                    chk("pwrite", 32'(pwrite), 32'(cur.wr));
                    chk("pwdata", 32'(pwdata), 32'(cur.wdata));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog at cycle %0d: got no finish, want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int a2;
        prst = 1'b1;
        drop();
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        step();
        step();
        prst  = 1'b0;
        armed = 1'b1;
        step();

        // Single write, ready in first ACCESS.
        issue(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 32'h5A5A5A5A, 1'b0, a);
        drop();
        chk("w_setup_psel", 32'(psel), 32'd1);
        chk("w_setup_penable", 32'(penable), 32'd0);
        step();
        chk("w_access_penable", 32'(penable), 32'd1);
        chk("w_access_pwdata", 32'(pwdata), 32'hDEADBEEF);
        step();
        chk("w_done_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w_done_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("w_done_rsp_err", 32'(rsp_err), 32'd0);
        chk("w_done_psel", 32'(psel), 32'd0);
        step();
        chk("w_after_rsp_valid", 32'(rsp_valid), 32'd0);

        // Read with three wait states.
        issue(1'b0, 8'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1'b0, a);
        drop();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r3_penable", 32'(penable), 32'd1);
            chk("r3_paddr", 32'(paddr), 32'h10);
        end
        step();
        chk("r3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r3_rsp_rdata", 32'(rsp_rdata), 32'hDEADBEEF);
        step();
        chk("r3_after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("r3_hold_rdata", 32'(rsp_rdata), 32'hDEADBEEF);

        // Back-to-back writes with cmd_valid held high.
        issue(1'b1, 8'h01, 32'h11111111, 0, 1'b0, 32'hA5A5A5A5, 1'b0, a);
        issue(1'b1, 8'h02, 32'h22222222, 0, 1'b0, 32'hA5A5A5A5, 1'b0, a2);
        drop();
        chk("b2b_psel", 32'(psel), 32'd1);
        chk("b2b_penable", 32'(penable), 32'd0);
        chk("b2b_rsp1", 32'(rsp_valid), 32'd1);
        chk("b2b_paddr", 32'(paddr), 32'h02);
        step();
        chk("b2b_gap_rsp", 32'(rsp_valid), 32'd0);
        step();
        chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
        chk("b2b_idle_psel", 32'(psel), 32'd0);

        // Timeout with pready held low.
        issue(1'b0, 8'h20, 32'h0, 0, 1'b1, 32'hBAD0BAD0, 1'b0, a);
        drop();
        for (int i = 0; i < 4; i++) step();
        step();
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("to_psel", 32'(psel), 32'd0);

        // Slave error on a read keeps the read data; on a write it returns zero.
        issue(1'b0, 8'h30, 32'h0, 0, 1'b0, 32'hCAFEF00D, 1'b1, a);
        drop();
        step();
        step();
        chk("serr_rd_err", 32'(rsp_err), 32'd1);
        chk("serr_rd_rdata", 32'(rsp_rdata), 32'hCAFEF00D);
        issue(1'b1, 8'h34, 32'h0BADF00D, 2, 1'b0, 32'h77777777, 1'b1, a);
        drop();
        for (int i = 0; i < 4; i++) step();
        chk("serr_wr_err", 32'(rsp_err), 32'd1);
        chk("serr_wr_rdata", 32'(rsp_rdata), 32'd0);

        // Reset during the second wait cycle abandons the transfer.
        issue(1'b0, 8'h40, 32'h0, 5, 1'b0, 32'h13572468, 1'b0, a);
        drop();
        step();
        step();
        prst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        q.delete();
        last_rdata = '0;
        last_err   = 1'b0;
        prst       = 1'b0;
        chk("mid_rst_psel", 32'(psel), 32'd0);
        chk("mid_rst_penable", 32'(penable), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        // Next command after reset runs normally.
        issue(1'b0, 8'h44, 32'h0, 1, 1'b0, 32'h12345678, 1'b0, a);
        drop();
        step();
        step();
        step();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post_rst_rdata", 32'(rsp_rdata), 32'h12345678);
        chk("post_rst_err", 32'(rsp_err), 32'd0);

        for (int i = 0; i < 5; i++) step();
        chk("end_psel", 32'(psel), 32'd0);
        chk("end_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
